// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core and its instruction memory.
package riscv_pkg;

  // addi x0, x0, 0 -- returned on any fetch that must not reach the array
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Loader sequencing: zero the array, take the boot stream, then let the core run
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Boot-stream, fetch and control signals between the instruction memory and its
// surroundings (boot source + core).
//
// Byte stream handshake: a byte transfers on a rising edge where ld_valid and
// ld_ready are both high. ld_byte and ld_last are only meaningful while ld_valid
// is high; the source holds them stable until the transfer happens. ld_ready may
// drop without a transfer (end of LOAD), and the source must not wait for ready
// before raising valid.
interface imem_loader_if #(
  parameter int NUM_INST = 128
);
  localparam int ADDR_W = $clog2(NUM_INST);

  logic [31:0]     pc;
  logic [31:0]     instruction;
  logic            fetch_fault;
  logic            ld_valid;
  logic            ld_ready;
  logic [7:0]      ld_byte;
  logic            ld_last;
  logic            reload;
  logic            core_run;
  logic [ADDR_W:0] prog_len;

  // Boot source / core side
  modport master (
    output pc, ld_valid, ld_byte, ld_last, reload,
    input  instruction, fetch_fault, ld_ready, core_run, prog_len
  );

  // Instruction memory side
  modport slave (
    input  pc, ld_valid, ld_byte, ld_last, reload,
    output instruction, fetch_fault, ld_ready, core_run, prog_len
  );

endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words. A word is
// presented (word_valid) in the same cycle as the byte that completes it, either
// by filling lane 3 or by carrying the last-byte flag; unfilled lanes read 0.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        word_last
);

  logic [1:0]  bcnt_q;
  logic [31:0] asm_q;

  // Current assembly with the incoming byte merged into its lane
  always_comb begin
    word = asm_q;
    word[{bcnt_q, 3'b000} +: 8] = in_byte;
  end

  assign word_valid = in_valid && ((bcnt_q == 2'd3) || in_last);
  assign word_last  = in_valid && in_last;

  // Lane counter and assembly register; emptied after each emitted word
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      bcnt_q <= 2'd0;
      asm_q  <= '0;
    end else if (in_valid) begin
      if (word_valid) begin
        bcnt_q <= 2'd0;
        asm_q  <= '0;
      end else begin
        bcnt_q <= bcnt_q + 2'd1;
        asm_q  <= word;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Writable instruction memory: self-clears after reset/reload, loads a byte
// stream into consecutive words from word 0, then releases the core. The fetch
// port is purely combinational so the core's single-cycle timing is untouched.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int NUM_INST = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus,
  output imem_state_t  dbg_state
);

  localparam int ADDR_W = $clog2(NUM_INST);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INST - 1);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_L     = (ADDR_W + 1)'(1);

  imem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W:0]   prog_len_q;
  logic [31:0]       mem [NUM_INST];

  logic        accept;
  logic [31:0] word;
  logic        word_valid;
  logic        word_last;

  assign accept = bus.ld_valid && (state_q == LOAD);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (state_q != LOAD),
    .in_valid   (accept),
    .in_byte    (bus.ld_byte),
    .in_last    (bus.ld_last),
    .word       (word),
    .word_valid (word_valid),
    .word_last  (word_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  // Next state: clear sweeps the whole array, load ends on last byte or full array
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (wptr_q == LAST_ADDR) state_d = LOAD;
      LOAD:    if (word_valid && (word_last || (wptr_q == LAST_ADDR))) state_d = RUN;
      RUN:     if (bus.reload) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  // Outputs decoded from the state register only, so they change on clock edges
  always_comb begin
    bus.ld_ready = (state_q == LOAD);
    bus.core_run = (state_q == RUN);
    dbg_state    = state_q;
  end

  // Write pointer and program length; reload rewinds so loading restarts at word 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      prog_len_q <= '0;
    end else begin
      unique case (state_q)
        CLEAR: wptr_q <= wptr_q + ONE_A;
        LOAD: if (word_valid) begin
          wptr_q     <= wptr_q + ONE_A;
          prog_len_q <= prog_len_q + ONE_L;
        end
        RUN: if (bus.reload) begin
          wptr_q     <= '0;
          prog_len_q <= '0;
        end
        default: wptr_q <= '0;
      endcase
    end
  end

  // Array write port: zeros while clearing, packed words while loading
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == CLEAR))
      mem[wptr_q] <= '0;
    else if (rst_n && (state_q == LOAD) && word_valid)
      mem[wptr_q] <= word;
  end

  assign bus.prog_len    = prog_len_q;
  assign bus.fetch_fault = (bus.pc[1:0] != 2'b00) || (bus.pc[31:ADDR_W+2] != '0);

  // Fetch mux: the array is only visible once loaded and for in-range aligned pcs
  always_comb begin
    if (bus.core_run && !bus.fetch_fault) bus.instruction = mem[bus.pc[ADDR_W+1:2]];
    else                                  bus.instruction = INSTR_NOP;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: one 128-word and one 8-word instance share the stimulus
// signals; sel8 picks which one sees ld_valid/reload and which one is observed.
module tb_imem_loader;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, sel8;
  logic [31:0] pc;
  logic ld_valid, ld_last, reload;
  logic [7:0] ld_byte;

  imem_loader_if #(.NUM_INST(128)) bus_a ();
  imem_loader_if #(.NUM_INST(8))   bus_b ();
  imem_state_t dbg_a, dbg_b;

  imem_loader #(.NUM_INST(128)) dut_a (.clk(clk), .rst_n(rst_a), .bus(bus_a), .dbg_state(dbg_a));
  imem_loader #(.NUM_INST(8))   dut_b (.clk(clk), .rst_n(rst_b), .bus(bus_b), .dbg_state(dbg_b));

  assign bus_a.pc       = pc;
  assign bus_a.ld_valid = ld_valid & ~sel8;
  assign bus_a.ld_byte  = ld_byte;
  assign bus_a.ld_last  = ld_last;
  assign bus_a.reload   = reload & ~sel8;
  assign bus_b.pc       = pc;
  assign bus_b.ld_valid = ld_valid & sel8;
  assign bus_b.ld_byte  = ld_byte;
  assign bus_b.ld_last  = ld_last;
  assign bus_b.reload   = reload & sel8;

  logic ready, run, fault;
  logic [31:0] instr;
  logic [7:0] plen;
  imem_state_t dbg;
  int depth;

  always_comb begin
    if (sel8) begin
      ready = bus_b.ld_ready; run = bus_b.core_run; fault = bus_b.fetch_fault;
      instr = bus_b.instruction; plen = 8'(bus_b.prog_len); dbg = dbg_b; depth = 8;
    end else begin
      ready = bus_a.ld_ready; run = bus_a.core_run; fault = bus_a.fetch_fault;
      instr = bus_a.instruction; plen = 8'(bus_a.prog_len); dbg = dbg_a; depth = 128;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  prog[$];
  int exp_len;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: bytes fill words little-endian from word 0, capped at the array size
  task automatic model_expect(input int dep);
    logic [31:0] mw [128];
    int n_acc;
    n_acc = prog.size();
    if (n_acc > 4 * dep) n_acc = 4 * dep;
    for (int w = 0; w < 128; w++) mw[w] = 32'h0;
    for (int b = 0; b < n_acc; b++) mw[b / 4][8 * (b % 4) +: 8] = prog[b];
    exp_q.delete();
    for (int w = 0; w < dep; w++) exp_q.push_back(mw[w]);
    exp_len = (n_acc + 3) / 4;
  endtask

  task automatic verify_mem(input string tag);
    logic [31:0] e;
    for (int w = 0; w < depth; w++) begin
      pc = 32'(w * 4);
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check_eq($sformatf("%s_w%0d", tag, w), instr, e);
    end
    check_eq({tag, "_len"}, 32'(plen), 32'(exp_len));
    pc = 32'h0;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_program(input bit use_last, input bit gaps, output int n_acc, output int n_cyc);
    int budget;
    n_acc = 0;
    n_cyc = 0;
    for (int i = 0; i < prog.size(); i++) begin
      if (run) break;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ld_valid = 1'b0; ld_last = 1'($urandom_range(0, 1)); ld_byte = 8'($urandom);
          @(negedge clk); n_cyc++;
        end
      end
      ld_valid = 1'b1;
      ld_byte  = prog[i];
      ld_last  = use_last && (i == prog.size() - 1);
      budget = 0;
      while (!ready && budget < 400) begin
        @(negedge clk); budget++; n_cyc++;
      end
      if (!ready) begin
        check_eq("ready_timeout", 32'(ready), 32'h1);
        break;
      end
      @(negedge clk);
      n_cyc++;
      n_acc++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (!ready && n < 1000) begin
      @(negedge clk); n++;
    end
    check_eq(tag, 32'(n), 32'(exp_cycles));
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_eq({tag, "_run_low"}, 32'(run), 32'h0);
    check_eq({tag, "_len_zero"}, 32'(plen), 32'h0);
    wait_ready({tag, "_clear_cycles"}, depth);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n_acc, n_cyc, bad_ready, bad_run, bad_instr;
    rst_a = 0; rst_b = 0; sel8 = 0;
    pc = 0; ld_valid = 0; ld_last = 0; ld_byte = 0; reload = 0;

    // Reset and clear, with valid pulsed while clearing
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    check_eq("reset_state", 32'(dbg), 32'(CLEAR));
    check_eq("reset_len", 32'(plen), 32'h0);
    bad_ready = 0; bad_run = 0; bad_instr = 0;
    for (int c = 0; c <= 128; c++) begin
      ld_valid = (c >= 10 && c < 20);
      ld_byte  = 8'hFF;
      ld_last  = (c >= 10 && c < 20);
      if (c < 128 && ready) bad_ready++;
      if (run) bad_run++;
      if (instr !== INSTR_NOP) bad_instr++;
      if (c < 128) @(negedge clk);
    end
    ld_valid = 0; ld_last = 0;
    check_eq("clear_ready_low", 32'(bad_ready), 32'h0);
    check_eq("clear_ready_at_128", 32'(ready), 32'h1);
    check_eq("clear_run_low", 32'(bad_run), 32'h0);
    check_eq("clear_instr_nop", 32'(bad_instr), 32'h0);

    // Fixed three-word program
    prog = '{8'h93, 8'h02, 8'hB0, 8'h07, 8'h13, 8'h03, 8'h80, 8'h1C, 8'hB3, 8'h83, 8'h62, 8'h00};
    send_program(1'b1, 1'b0, n_acc, n_cyc);
    check_eq("prog_accepts", 32'(n_acc), 32'd12);
    check_eq("prog_cycles", 32'(n_cyc), 32'd12);
    check_eq("prog_run", 32'(run), 32'h1);
    check_eq("prog_ready_low", 32'(ready), 32'h0);
    model_expect(depth);
    verify_mem("prog");

    // Fetch faults
    pc = 32'd2;   #1; check_eq("fault_pc2", 32'(fault), 32'h1); check_eq("nop_pc2", instr, INSTR_NOP);
    pc = 32'd1;   #1; check_eq("fault_pc1", 32'(fault), 32'h1);
    pc = 32'd512; #1; check_eq("fault_pc512", 32'(fault), 32'h1); check_eq("nop_pc512", instr, INSTR_NOP);
    pc = 32'd508; #1; check_eq("fault_pc508", 32'(fault), 32'h0); check_eq("instr_pc508", instr, 32'h0);
    pc = 32'hFFFF_FFFC; #1; check_eq("fault_pc_high", 32'(fault), 32'h1);
    pc = 32'd4;   #1; check_eq("fault_pc4", 32'(fault), 32'h0);
    pc = 0;
    @(negedge clk);

    // Partial trailing word
    do_reload("rl1");
    prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    send_program(1'b1, 1'b0, n_acc, n_cyc);
    check_eq("partial_run", 32'(run), 32'h1);
    model_expect(depth);
    verify_mem("partial");

    // Random program, gap-free then with valid gaps
    prog.delete();
    repeat ($urandom_range(5, 40)) prog.push_back(8'($urandom));
    do_reload("rl2");
    send_program(1'b1, 1'b0, n_acc, n_cyc);
    check_eq("rand_cycles", 32'(n_cyc), 32'(prog.size()));
    model_expect(depth);
    verify_mem("rand_nogap");
    do_reload("rl3");
    send_program(1'b1, 1'b1, n_acc, n_cyc);
    check_eq("gap_accepts", 32'(n_acc), 32'(prog.size()));
    model_expect(depth);
    verify_mem("rand_gap");

    // 8-word instance: fill without last, reload, reset mid-load
    sel8 = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    wait_ready("b_clear_cycles", 8);
    prog.delete();
    repeat (32) prog.push_back(8'($urandom));
    send_program(1'b0, 1'b0, n_acc, n_cyc);
    check_eq("fill_accepts", 32'(n_acc), 32'd32);
    check_eq("fill_run", 32'(run), 32'h1);
    ld_valid = 1'b1; ld_byte = 8'h55;
    bad_ready = 0;
    repeat (3) begin
      if (ready) bad_ready++;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    check_eq("fill_no_accept", 32'(bad_ready), 32'h0);
    model_expect(depth);
    verify_mem("fill");

    do_reload("b_rl");
    prog = '{8'h5A};
    send_program(1'b1, 1'b0, n_acc, n_cyc);
    model_expect(depth);
    verify_mem("after_reload");

    do_reload("b_rl2");
    prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_program(1'b0, 1'b0, n_acc, n_cyc);
    check_eq("mid_len", 32'(plen), 32'h1);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    check_eq("rst_mid_len", 32'(plen), 32'h0);
    check_eq("rst_mid_state", 32'(dbg), 32'(CLEAR));
    check_eq("rst_mid_run", 32'(run), 32'h0);
    wait_ready("rst_mid_clear", 8);
    prog = '{8'hC3, 8'hB2, 8'hA1};
    send_program(1'b1, 1'b0, n_acc, n_cyc);
    model_expect(depth);
    verify_mem("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
